// File: rtl/k2_pkg.sv
// Shared types for the K2 instruction fetch front-end.
package k2_pkg;

  localparam int ADDR_W = 4;
  localparam int INST_W = 8;

  typedef struct packed {
    logic [3:0] opcode;
    logic       flag;
    logic [2:0] operand;
  } inst_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    inst_t             inst;
  } fetch_entry_t;

endpackage

// File: rtl/k2_fetch_fifo.sv
// Synchronous DEPTH-entry FIFO of fetch entries; flush outranks push and pop.
module k2_fetch_fifo
  import k2_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_push,
  input  logic               i_pop,
  input  logic               i_flush,
  input  fetch_entry_t       i_din,
  output fetch_entry_t       o_dout,
  output logic [CNT_W-1:0]   o_count,
  output logic               o_full,
  output logic               o_empty
);

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd;
  logic [PTR_W-1:0] r_wr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_pop;
  logic             w_do_push;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign o_count   = r_count;
  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_dout    = r_mem[r_rd];
  assign w_do_pop  = i_pop & ~o_empty;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr] <= i_din;
        r_wr        <= next_ptr(r_wr);
      end
      if (w_do_pop) begin
        r_rd <= next_ptr(r_rd);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/k2_instr_fetch.sv
// K2 instruction fetch: PC register, ROM read, prefetch queue and redirect flush.
module k2_instr_fetch
  import k2_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  output logic [ADDR_W-1:0] o_pm_addr,
  input  logic [INST_W-1:0] i_pm_inst,
  input  logic              i_redirect_valid,
  input  logic [ADDR_W-1:0] i_redirect_addr,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [INST_W-1:0] o_out_inst,
  output logic [ADDR_W-1:0] o_out_pc,
  output logic [3:0]        o_out_opcode,
  output logic              o_out_flag,
  output logic [2:0]        o_out_operand
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] r_pc;
  logic              w_pop;
  logic              w_push;
  logic              w_full;
  logic              w_empty;
  logic [CNT_W-1:0]  w_count;
  fetch_entry_t      w_din;
  fetch_entry_t      w_raw_head;
  fetch_entry_t      w_head;

  assign w_din.pc   = r_pc;
  assign w_din.inst = inst_t'(i_pm_inst);

  assign o_out_valid = (w_count != '0);
  assign w_pop       = o_out_valid & i_out_ready;
  assign w_push      = i_en & ~i_redirect_valid & (~w_full | w_pop);

  k2_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (i_redirect_valid),
    .i_din   (w_din),
    .o_dout  (w_raw_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Stale storage is hidden so the head reads zero whenever nothing is queued.
  assign w_head        = w_empty ? '0 : w_raw_head;
  assign o_out_pc      = w_head.pc;
  assign o_out_inst    = w_head.inst;
  assign o_out_opcode  = w_head.inst.opcode;
  assign o_out_flag    = w_head.inst.flag;
  assign o_out_operand = w_head.inst.operand;
  assign o_pm_addr     = r_pc;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pc <= '0;
    end else if (i_redirect_valid) begin
      r_pc <= i_redirect_addr;
    end else if (w_push) begin
      r_pc <= r_pc + ADDR_W'(1);
    end else begin
      r_pc <= r_pc;
    end
  end

endmodule

// File: tb/tb_k2_instr_fetch.sv
// Directed bench for k2_instr_fetch with a queue-based reference model.
module tb_k2_instr_fetch;
  import k2_pkg::*;

  localparam int DEPTH = 2;

  logic              clk;
  logic              rst;
  logic              en;
  logic [ADDR_W-1:0] pm_addr;
  logic [INST_W-1:0] pm_inst;
  logic              redir;
  logic [ADDR_W-1:0] raddr;
  logic              out_valid;
  logic              ready;
  logic [INST_W-1:0] out_inst;
  logic [ADDR_W-1:0] out_pc;
  logic [3:0]        out_opcode;
  logic              out_flag;
  logic [2:0]        out_operand;

  logic [7:0]  rom [16];
  logic [11:0] m_q [$];
  int          m_pc;
  int          vectors;
  int          miscompares;

  k2_instr_fetch #(.DEPTH(DEPTH)) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_en             (en),
    .o_pm_addr        (pm_addr),
    .i_pm_inst        (pm_inst),
    .i_redirect_valid (redir),
    .i_redirect_addr  (raddr),
    .o_out_valid      (out_valid),
    .i_out_ready      (ready),
    .o_out_inst       (out_inst),
    .o_out_pc         (out_pc),
    .o_out_opcode     (out_opcode),
    .o_out_flag       (out_flag),
    .o_out_operand    (out_operand)
  );

  assign pm_inst = rom[pm_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a FIFO of {pc, inst} plus a PC, stepped on each rising edge.
  always @(posedge clk) begin : model
    int sz;
    bit pop;
    bit push;
    if (rst) begin
      m_q.delete();
      m_pc = 0;
    end else begin
      sz  = m_q.size();
      pop = (sz > 0) && ready;
      if (redir) begin
        m_q.delete();
        m_pc = int'(raddr);
      end else begin
        push = en && ((sz < DEPTH) || pop);
        if (pop) void'(m_q.pop_front());
        if (push) begin
          m_q.push_back({4'(m_pc), rom[m_pc]});
          m_pc = (m_pc + 1) % 16;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_check();
    logic [11:0] head;
    logic        v;
    v    = (m_q.size() > 0);
    head = v ? m_q[0] : 12'h000;
    chk("m_valid",   32'(out_valid),   32'(v));
    chk("m_pm_addr", 32'(pm_addr),     32'(m_pc));
    chk("m_pc",      32'(out_pc),      32'(head[11:8]));
    chk("m_inst",    32'(out_inst),    32'(head[7:0]));
    chk("m_opcode",  32'(out_opcode),  32'(head[7:4]));
    chk("m_flag",    32'(out_flag),    32'(head[3]));
    chk("m_operand", 32'(out_operand), 32'(head[2:0]));
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    model_check();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rom[0] = 8'h0A; rom[1] = 8'hF8; rom[2] = 8'h0D; rom[3] = 8'hF9;
    for (int i = 4; i < 16; i++) rom[i] = 8'(8'h30 + i);
    rst = 1'b1; en = 1'b0; ready = 1'b0; redir = 1'b0; raddr = 4'd0;
    tick(); tick();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_addr",  32'(pm_addr),   32'd0);
    chk("rst_inst",  32'(out_inst),  32'd0);

    // 1: straight-line stream
    rst = 1'b0; en = 1'b1; ready = 1'b1;
    tick(); chk("t1_pc0", 32'(out_pc), 32'd0); chk("t1_inst0", 32'(out_inst), 32'h0A);
    tick(); chk("t1_pc1", 32'(out_pc), 32'd1); chk("t1_inst1", 32'(out_inst), 32'hF8);
    chk("t1_opc", 32'(out_opcode), 32'hF); chk("t1_flag", 32'(out_flag), 32'd1);
    tick(); chk("t1_pc2", 32'(out_pc), 32'd2); chk("t1_inst2", 32'(out_inst), 32'h0D);
    tick(); chk("t1_pc3", 32'(out_pc), 32'd3); chk("t1_oper3", 32'(out_operand), 32'd1);

    // 2: backpressure from a fresh start
    rst = 1'b1; tick();
    rst = 1'b0; en = 1'b1; ready = 1'b0;
    repeat (6) tick();
    chk("t2_addr", 32'(pm_addr), 32'd2); chk("t2_valid", 32'(out_valid), 32'd1);
    chk("t2_head", 32'(out_pc), 32'd0);
    ready = 1'b1;
    tick(); chk("t2_pc1", 32'(out_pc), 32'd1);
    tick(); chk("t2_pc2", 32'(out_pc), 32'd2);
    tick(); chk("t2_pc3", 32'(out_pc), 32'd3);
    tick(); chk("t2_pc4", 32'(out_pc), 32'd4);

    // 3: redirect discards queued pcs 4,5
    ready = 1'b0; redir = 1'b1; raddr = 4'd9;
    tick(); chk("t3_flush", 32'(out_valid), 32'd0); chk("t3_addr", 32'(pm_addr), 32'd9);
    redir = 1'b0; ready = 1'b1;
    tick(); chk("t3_pc9", 32'(out_pc), 32'd9); chk("t3_inst9", 32'(out_inst), 32'h39);

    // 4: wrap from 14
    redir = 1'b1; raddr = 4'd14;
    tick(); redir = 1'b0;
    tick(); chk("t4_pc14", 32'(out_pc), 32'd14);
    tick(); chk("t4_pc15", 32'(out_pc), 32'd15);
    tick(); chk("t4_pc0",  32'(out_pc), 32'd0);
    tick(); chk("t4_pc1",  32'(out_pc), 32'd1);

    // 5: drain with en=0
    ready = 1'b0; tick();
    en = 1'b0; ready = 1'b1;
    tick(); chk("t5_pc2", 32'(out_pc), 32'd2);
    tick(); chk("t5_empty", 32'(out_valid), 32'd0); chk("t5_addr", 32'(pm_addr), 32'd3);
    tick(); chk("t5_hold", 32'(pm_addr), 32'd3);

    // redirect while disabled, then redirect to current pc
    redir = 1'b1; raddr = 4'd5;
    tick(); chk("rd_addr", 32'(pm_addr), 32'd5);
    redir = 1'b0;
    tick(); chk("rd_wait", 32'(out_valid), 32'd0);
    en = 1'b1;
    tick(); chk("rd_pc5", 32'(out_pc), 32'd5);
    ready = 1'b0; redir = 1'b1; raddr = 4'd6;
    tick(); chk("rs_flush", 32'(out_valid), 32'd0);
    redir = 1'b0; ready = 1'b1;
    tick(); chk("rs_pc6", 32'(out_pc), 32'd6);

    // 6: reset beats a simultaneous redirect
    rst = 1'b1; redir = 1'b1; raddr = 4'd7;
    tick(); chk("t6_valid", 32'(out_valid), 32'd0); chk("t6_addr", 32'(pm_addr), 32'd0);
    rst = 1'b0; redir = 1'b0;
    tick(); chk("t6_pc0", 32'(out_pc), 32'd0); chk("t6_inst0", 32'(out_inst), 32'h0A);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
